// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM responder: FSM encodings and fixed limits.
package dram_pkg;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_SERVE = 1'b1
  } dram_state_e;

  localparam int RD_LAT_MAX     = 8;
  localparam int DRAM_CNT_WIDTH = 32;

endpackage

// File: rtl/dram_responder_array.sv
// 1R1W synchronous word array with a single registered read port.
// A read and write to the same word in one cycle returns the old contents.
module dram_responder_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 65536,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately never reset so preloaded data survives srstn.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder for the accelerator DRAM port: host preload, then
// fixed-latency single-beat reads and writes with range checking and counters.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_LOAD  | host load port owns the write port; accelerator requests ignored
//   ST_SERVE | accelerator reads/writes served every cycle until reset
module dram_responder
  import dram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int DEPTH      = 65536,
  parameter int RD_LAT     = 2
) (
  input  logic                      clk,
  input  logic                      srstn,
  input  logic                      ld_valid,
  input  logic [ADDR_WIDTH-1:0]     ld_addr,
  input  logic [DATA_WIDTH-1:0]     ld_data,
  input  logic                      ld_last,
  input  logic                      dram_en_rd,
  input  logic [ADDR_WIDTH-1:0]     addr_in,
  input  logic                      dram_en_wr,
  input  logic [ADDR_WIDTH-1:0]     addr_out,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      dram_valid,
  output logic                      rdy_data,
  output logic                      addr_err,
  output logic [DRAM_CNT_WIDTH-1:0] rd_cnt,
  output logic [DRAM_CNT_WIDTH-1:0] wr_cnt
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  dram_state_e           state;
  logic                  rd_oor, wr_oor, ld_oor;
  logic                  rd_acc, wr_acc, ld_acc;
  logic                  err_hit;
  logic                  arr_we;
  logic [AW-1:0]         arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  oor_q1;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [RD_LAT:1]       vld;

  assign rd_oor = 32'(addr_in)  >= DEPTH_W;
  assign wr_oor = 32'(addr_out) >= DEPTH_W;
  assign ld_oor = 32'(ld_addr)  >= DEPTH_W;

  assign rd_acc = (state == ST_SERVE) && dram_en_rd;
  assign wr_acc = (state == ST_SERVE) && dram_en_wr;
  assign ld_acc = (state == ST_LOAD)  && ld_valid;

  assign err_hit = (ld_acc && ld_oor) || (rd_acc && rd_oor) || (wr_acc && wr_oor);

  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = '0;
    arr_wdata = '0;
    if (state == ST_LOAD) begin
      arr_we    = ld_acc && !ld_oor;
      arr_waddr = ld_addr[AW-1:0];
      arr_wdata = ld_data;
    end else begin
      arr_we    = wr_acc && !wr_oor;
      arr_waddr = addr_out[AW-1:0];
      arr_wdata = data_in;
    end
  end

  dram_responder_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (rd_acc),
    .raddr (addr_in[AW-1:0]),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state    <= ST_LOAD;
      rdy_data <= 1'b0;
      addr_err <= 1'b0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (ld_valid && ld_last) begin
            state    <= ST_SERVE;
            rdy_data <= 1'b1;
          end
        end
        ST_SERVE: begin
          rdy_data <= 1'b1;
          if (rd_acc) rd_cnt <= rd_cnt + DRAM_CNT_WIDTH'(1);
          if (wr_acc) wr_cnt <= wr_cnt + DRAM_CNT_WIDTH'(1);
        end
        default: state <= ST_LOAD;
      endcase
      if (err_hit) addr_err <= 1'b1;
    end
  end

  // Stage 1 is the array read register; its range flag rides alongside so
  // out-of-range reads come back as zero.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      vld    <= '0;
      oor_q1 <= 1'b0;
    end else begin
      vld[1] <= rd_acc;
      oor_q1 <= rd_oor;
      for (int k = 2; k <= RD_LAT; k++) vld[k] <= vld[k-1];
    end
  end

  assign s1_data    = oor_q1 ? '0 : arr_rdata;
  assign dram_valid = vld[RD_LAT];

  generate
    if (RD_LAT == 1) begin : g_lat1
      logic [DATA_WIDTH-1:0] hold_q;

      always_ff @(posedge clk or negedge srstn) begin
        if (!srstn)      hold_q <= '0;
        else if (vld[1]) hold_q <= s1_data;
      end

      assign data_out = vld[1] ? s1_data : hold_q;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] dpipe [2:RD_LAT];

      // Each stage only loads on valid, so the last stage holds between strobes.
      always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
          for (int k = 2; k <= RD_LAT; k++) dpipe[k] <= '0;
        end else begin
          if (vld[1]) dpipe[2] <= s1_data;
          for (int k = 3; k <= RD_LAT; k++)
            if (vld[k-1]) dpipe[k] <= dpipe[k-1];
        end
      end

      assign data_out = dpipe[RD_LAT];
    end
  endgenerate

endmodule
